fp_divider_single: RTL
======================

# fp_divider_single

Sequential IEEE-754 single-precision divider (out = a / b), the inverse companion of the team's single-precision multiplier in the floating-point arithmetic unit. It uses a start/done handshake and computes the quotient mantissa with a radix-2 restoring divider, one bit per clock. Denormals are flushed to zero. Output rounding is fixed at build time.

## Interface
- No parameters. All widths are fixed by the single-precision format.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request; sampled only while busy=0.
- a  in  32  dividend, IEEE-754 single precision.
- b  in  32  divisor, IEEE-754 single precision.
- busy  out  1  high from the edge that accepts start until the edge that raises done.
- done  out  1  one-cycle pulse; out is valid from this cycle on.
- out  out  32  quotient; held until the next done.

## Operation
- States and transitions:
  - IDLE: on start=1, latch a and b, then go to DIV.
  - DIV: run exactly 26 iterations, then go to NORM.
  - NORM: on the next edge write out, pulse done, go to IDLE.
- Operand classes:
  - zero: exp=0, covering both zero and denormal inputs.
  - inf: exp=255 with mantissa=0.
  - nan: exp=255 with mantissa≠0.
  - normal: any other value.
- Sign = a[31] ^ b[31]. The sign is forced to 0 only for qNaN.
- Special results:
  - Any nan, 0/0 or inf/inf gives 32'h7FC00000.
  - x/0 with x≠0, and inf/x, give {sign, 8'hFF, 23'd0}.
  - 0/x and x/inf give {sign, 31'd0}.
- Every special case still takes the full latency.
- Mantissas: ma = {1, a[22:0]}, mb = {1, b[22:0]}, both 24 bits.
- Quotient: q[25:0] = floor(ma·2^25 / mb). rem is the final remainder.
- Restoring step, once per DIV cycle:
  - Form a 25-bit trial remainder r - mb.
  - If the trial is non-negative, shift in quotient bit 1 and keep the difference.
  - Otherwise shift in 0 and keep r.
- Exponent: e = a_exp - b_exp + 127, computed as 10-bit signed.
- Normalisation:
  - If q[25]=1: mant = q[24:2], guard = q[1], sticky = q[0] | (rem≠0).
  - Otherwise: mant = q[23:1], guard = q[0], sticky = (rem≠0), and e = e - 1.
- Range limits, applied after rounding:
  - e ≥ 255 gives signed infinity.
  - e ≤ 0 gives signed zero (flush, no denormal output).
- Reset: state=IDLE, busy=0, done=0, out=32'd0. All internal registers are cleared.
- Reset mid-operation abandons the calculation. No done is produced and out stays 0.
- start while busy=1 is ignored and is not queued.
- start in the same cycle as done (state NORM) is ignored. It is accepted in the next cycle.

## Timing
- start sampled high at edge T. busy is high from T through edge T+27.
- done and the new out are registered at edge T+28.
- busy falls at T+28.
- Latency: 28 cycles. Throughput: one operation per 29 cycles.
- done stays high for exactly one cycle.

## Configuration
- FP_DIV_ROUND_EN defined:
  - Round-to-nearest-even: increment mant when guard & (sticky | mant[0]).
  - A mantissa carry-out sets mant=0 and e = e + 1.
  - The range check is applied after the increment.
- FP_DIV_ROUND_EN undefined: truncate. guard and sticky are ignored, matching the multiplier's truncating behaviour.
- Latency is identical in both builds.

## Structure
- Package fp_pkg holds:
  - constants FP_BIAS=127, FP_EXP_MAX=255, FP_QNAN=32'h7FC00000, FP_EXP_W=8, FP_MAN_W=23, DIV_ITERS=26;
  - the state enum {IDLE, DIV, NORM};
  - the operand-class enum {ZERO, NORMAL, INF, NAN}.
- One sub-module, fp_div_normround: a combinational block that takes q, rem, e and sign and produces the packed 32-bit result. The top level keeps the FSM, the iteration counter and the remainder/quotient registers.

## Test plan
- 6.0/2.0: a=40C00000, b=40000000 → out=40400000, done exactly 28 edges after start.
- 1.0/3.0: a=3F800000, b=40400000 → out=3EAAAAAB with FP_DIV_ROUND_EN, 3EAAAAAA without it.
- Specials:
  - -1.0/0: a=BF800000, b=0 → FF800000.
  - 0/0 → 7FC00000.
  - 0/5.0 (b=40A00000) → 00000000.
- Range limits:
  - 7F000000/3E800000 → 7F800000 (overflow).
  - 00800000/40000000 → 00000000 (flush).
- Busy behaviour: second start with different operands at T+5 is ignored. The single done at T+28 carries the first result, and busy returns to 0.
- Reset: rst_n pulsed low at T+10 → busy=0, done never pulses, out=0. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, state/class enums and operand classifier for the
// single-precision divider.
package fp_pkg;

   localparam int          FP_BIAS    = 127;
   localparam int          FP_EXP_MAX = 255;
   localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
   localparam int          FP_EXP_W   = 8;
   localparam int          FP_MAN_W   = 23;
   localparam int          DIV_ITERS  = 26;

   typedef enum logic [1:0] {IDLE, DIV, NORM} state_e;

   typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} cls_e;

   // Denormals fall into ZERO because the exponent field alone decides it.
   function automatic cls_e classify(input logic [31:0] x);
      logic [FP_EXP_W-1:0] ex;
      logic [FP_MAN_W-1:0] man;
      ex  = x[30:23];
      man = x[22:0];
      if (ex == '0) begin
         return ZERO;
      end else if (ex == FP_EXP_W'(FP_EXP_MAX)) begin
         return (man == '0) ? INF : NAN;
      end else begin
         return NORMAL;
      end
   endfunction

endpackage

// File: rtl/fp_div_normround.sv
// Normalises the restoring-divider quotient, rounds (only when FP_DIV_ROUND_EN
// is defined, otherwise truncates) and packs the single-precision result.
module fp_div_normround
   import fp_pkg::*;
(
   input  logic [25:0]       q,
   input  logic [24:0]       rem,
   input  logic signed [9:0] e,
   input  logic              sign,
   output logic [31:0]       res
);

   logic [FP_MAN_W-1:0] mant;
   logic                guard;
   logic                sticky;
   logic signed [9:0]   e_n;

`ifdef FP_DIV_ROUND_EN
   logic [FP_MAN_W:0]   mant_inc;
`else
   logic                unused_round_bits;
`endif

   always_comb begin
      // q lies in [2^24, 2^26), so only the top bit decides the shift.
      if (q[25]) begin
         mant   = q[24:2];
         guard  = q[1];
         sticky = q[0] | (|rem);
         e_n    = e;
      end else begin
         mant   = q[23:1];
         guard  = q[0];
         sticky = |rem;
         e_n    = e - 10'sd1;
      end

`ifdef FP_DIV_ROUND_EN
      mant_inc = {1'b0, mant} + 24'd1;
      if (guard & (sticky | mant[0])) begin
         mant = mant_inc[FP_MAN_W-1:0];
         if (mant_inc[FP_MAN_W]) begin
            e_n = e_n + 10'sd1;
         end
      end
`endif

      if (e_n >= $signed(10'(FP_EXP_MAX))) begin
         res = {sign, {FP_EXP_W{1'b1}}, {FP_MAN_W{1'b0}}};
      end else if (e_n <= 10'sd0) begin
         res = {sign, 31'd0};
      end else begin
         res = {sign, e_n[FP_EXP_W-1:0], mant};
      end
   end

`ifndef FP_DIV_ROUND_EN
   assign unused_round_bits = guard ^ sticky;
`endif

endmodule

// File: rtl/fp_divider_single.sv
// Sequential IEEE-754 single-precision divider, radix-2 restoring, 28-cycle
// latency. Define FP_DIV_ROUND_EN for round-to-nearest-even, else truncation.
module fp_divider_single
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] out
);

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [24:0] r_q, r_d;
   logic [25:0] quo_q, quo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] out_q, out_d;

   logic [23:0]       mb;
   logic [25:0]       trial;
   logic signed [9:0] exp_diff;
   logic              sign;
   cls_e              cls_a, cls_b;
   logic [31:0]       norm_res;
   logic [31:0]       result;

   assign mb       = {1'b1, b_q[22:0]};
   assign trial    = {1'b0, r_q} - {2'b00, mb};
   assign exp_diff = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
                     + $signed(10'(FP_BIAS));
   assign sign     = a_q[31] ^ b_q[31];
   assign cls_a    = classify(a_q);
   assign cls_b    = classify(b_q);

   fp_div_normround u_normround (
      .q    (quo_q),
      .rem  (r_q),
      .e    (exp_diff),
      .sign (sign),
      .res  (norm_res)
   );

   // Specials override the datapath, which still runs so latency is constant.
   always_comb begin
      result = norm_res;
      if (cls_a == NAN || cls_b == NAN ||
          (cls_a == ZERO && cls_b == ZERO) ||
          (cls_a == INF && cls_b == INF)) begin
         result = FP_QNAN;
      end else if (cls_b == ZERO || cls_a == INF) begin
         result = {sign, {FP_EXP_W{1'b1}}, {FP_MAN_W{1'b0}}};
      end else if (cls_a == ZERO || cls_b == INF) begin
         result = {sign, 31'd0};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      quo_d   = quo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = DIV;
            end
         end
         DIV: begin
            // Count 0 loads the dividend mantissa; counts 1..26 are the iterations.
            if (cnt_q == '0) begin
               r_d   = {1'b0, 1'b1, a_q[22:0]};
               quo_d = '0;
            end else if (!trial[25]) begin
               r_d   = trial[24:0] << 1;
               quo_d = {quo_q[24:0], 1'b1};
            end else begin
               r_d   = r_q << 1;
               quo_d = {quo_q[24:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(DIV_ITERS)) begin
               state_d = NORM;
            end
         end
         NORM: begin
            out_d   = result;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         quo_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         quo_q   <= quo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         out_q   <= out_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign out  = out_q;

endmodule
